// File: rtl/ifetch_queue_filler.sv
// Fetch front end: walks the PC, reads instruction memory over req/ack, and pushes {pc, instr} into the instruction FIFO.
// Two cycles per instruction (request/ack, then push); holds in push while the FIFO is full; redirect flushes the FIFO in one cycle.
module ifetch_queue_filler #(
    parameter int unsigned               INSTR_WIDTH = 32,
    parameter int unsigned               PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]       RESET_PC    = '0,
    parameter int unsigned               PC_STEP     = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stop_IN,
    input  logic                            redirect_IN,
    input  logic [PC_WIDTH-1:0]             redirectPC_IN,
    output logic                            memReq_OUT,
    output logic [PC_WIDTH-1:0]             memAddr_OUT,
    input  logic                            memAck_IN,
    input  logic [INSTR_WIDTH-1:0]          memData_IN,
    input  logic                            qFull_IN,
    output logic                            qPushReq_OUT,
    output logic [PC_WIDTH+INSTR_WIDTH-1:0] qData_OUT,
    output logic                            qFlush_OUT,
    output logic [PC_WIDTH-1:0]             pc_OUT,
    output logic [15:0]                     fetchCount_OUT
);

    typedef enum logic [1:0] {
        S_START,
        S_REQ,
        S_PUSH,
        S_FLUSH
    } state_t;

    state_t                          state;
    logic [PC_WIDTH-1:0]             pc;
    logic [PC_WIDTH+INSTR_WIDTH-1:0] hold;
    logic [15:0]                     fetch_count;

    // Handshake strobes decode straight from state so stop/full/redirect act within the cycle.
    assign memReq_OUT     = (state == S_REQ) && !stop_IN;
    assign qPushReq_OUT   = (state == S_PUSH) && !qFull_IN && !redirect_IN;
    assign qFlush_OUT     = (state == S_FLUSH);
    assign memAddr_OUT    = pc;
    assign pc_OUT         = pc;
    assign qData_OUT      = hold;
    assign fetchCount_OUT = fetch_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_START;
            pc          <= RESET_PC;
            hold        <= '0;
            fetch_count <= '0;
        end else if (redirect_IN) begin
            // Redirect wins everywhere: any ack or push opportunity this cycle is dropped.
            state <= S_FLUSH;
            pc    <= redirectPC_IN;
            hold  <= '0;
        end else begin
            case (state)
                S_START: state <= S_REQ;
                S_REQ: begin
                    if (!stop_IN && memAck_IN) begin
                        hold  <= {pc, memData_IN};
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!qFull_IN) begin
                        pc          <= pc + PC_WIDTH'(PC_STEP);
                        fetch_count <= fetch_count + 16'd1;
                        state       <= S_REQ;
                    end
                end
                S_FLUSH: state <= S_REQ;
                default: state <= S_START;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue_filler.sv
// Bench for ifetch_queue_filler: scripted scenarios with a scoreboard of expected FIFO entries.
module tb_ifetch_queue_filler;

    logic        clk;
    logic        reset;
    logic        stop_IN;
    logic        redirect_IN;
    logic [31:0] redirectPC_IN;
    logic        memReq_OUT;
    logic [31:0] memAddr_OUT;
    logic        memAck_IN;
    logic [31:0] memData_IN;
    logic        qFull_IN;
    logic        qPushReq_OUT;
    logic [63:0] qData_OUT;
    logic        qFlush_OUT;
    logic [31:0] pc_OUT;
    logic [15:0] fetchCount_OUT;

    int          n_vec;
    int          n_err;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;

    ifetch_queue_filler dut (
        .clk            (clk),
        .reset          (reset),
        .stop_IN        (stop_IN),
        .redirect_IN    (redirect_IN),
        .redirectPC_IN  (redirectPC_IN),
        .memReq_OUT     (memReq_OUT),
        .memAddr_OUT    (memAddr_OUT),
        .memAck_IN      (memAck_IN),
        .memData_IN     (memData_IN),
        .qFull_IN       (qFull_IN),
        .qPushReq_OUT   (qPushReq_OUT),
        .qData_OUT      (qData_OUT),
        .qFlush_OUT     (qFlush_OUT),
        .pc_OUT         (pc_OUT),
        .fetchCount_OUT (fetchCount_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memd(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Instruction memory model: contents are a fixed function of the address.
    assign memData_IN = memd(memAddr_OUT);

    // Push monitor: every push must match the oldest expected entry and obey full/flush rules.
    always @(negedge clk) begin
        if (reset && qPushReq_OUT) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL push_unexpected: got qData=%h, required no push", qData_OUT);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (qData_OUT !== e) begin
                    n_err++;
                    $display("FAIL push_data: got %h, required %h", qData_OUT, e);
                end
            end
            n_vec++;
            if (qFull_IN !== 1'b0 || qFlush_OUT !== 1'b0) begin
                n_err++;
                $display("FAIL push_rules: got full=%b flush=%b, required both 0", qFull_IN, qFlush_OUT);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stop_IN = 1'b0; redirect_IN = 1'b0; redirectPC_IN = '0;
        memAck_IN = 1'b0; qFull_IN = 1'b0;
        exp_pc = 32'h0; exp_cnt = 16'h0;
        repeat (2) step();
        @(negedge clk);
        n_vec++;
        if ({memReq_OUT, qPushReq_OUT, qFlush_OUT} !== 3'b000 || memAddr_OUT !== 32'h0 ||
            pc_OUT !== 32'h0 || fetchCount_OUT !== 16'h0 || qData_OUT !== 64'h0) begin
            n_err++;
            $display("FAIL reset_state: got req=%b push=%b flush=%b addr=%h pc=%h cnt=%0d data=%h, required all zero",
                     memReq_OUT, qPushReq_OUT, qFlush_OUT, memAddr_OUT, pc_OUT, fetchCount_OUT, qData_OUT);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        memAck_IN = 1'b1;
        @(negedge clk);
        n_vec++;
        if (memReq_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL start_req: got %b, required 0", memReq_OUT);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (memReq_OUT !== 1'b1 || memAddr_OUT !== exp_pc) begin
                n_err++;
                $display("FAIL basic_req%0d: got req=%b addr=%h, required 1 %h", i, memReq_OUT, memAddr_OUT, exp_pc);
            end
            exp_q.push_back({exp_pc, memd(exp_pc)});
            step();
            @(negedge clk);
            n_vec++;
            if (qPushReq_OUT !== 1'b1 || memReq_OUT !== 1'b0) begin
                n_err++;
                $display("FAIL basic_push%0d: got push=%b req=%b, required 1 0", i, qPushReq_OUT, memReq_OUT);
            end
            exp_pc += 32'd4; exp_cnt++;
            step();
        end
        @(negedge clk);
        n_vec++;
        if (fetchCount_OUT !== exp_cnt || memAddr_OUT !== exp_pc) begin
            n_err++;
            $display("FAIL basic_count: got cnt=%0d addr=%h, required %0d %h", fetchCount_OUT, memAddr_OUT, exp_cnt, exp_pc);
        end
        memAck_IN = 1'b0;
    endtask

    task automatic test_full();
        // One plain fetch at 0xC brings the PC to 0x10.
        memAck_IN = 1'b1;
        exp_q.push_back({exp_pc, memd(exp_pc)});
        step(); exp_pc += 32'd4; exp_cnt++;
        step();
        qFull_IN = 1'b1;
        @(negedge clk);
        n_vec++;
        if (memAddr_OUT !== 32'h10 || memReq_OUT !== 1'b1) begin
            n_err++;
            $display("FAIL full_req: got addr=%h req=%b, required 00000010 1", memAddr_OUT, memReq_OUT);
        end
        exp_q.push_back({exp_pc, memd(exp_pc)});
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (qPushReq_OUT !== 1'b0 || memReq_OUT !== 1'b0) begin
                n_err++;
                $display("FAIL full_hold%0d: got push=%b req=%b, required 0 0", i, qPushReq_OUT, memReq_OUT);
            end
            step();
        end
        qFull_IN = 1'b0; memAck_IN = 1'b0;
        @(negedge clk);
        n_vec++;
        if (qPushReq_OUT !== 1'b1) begin
            n_err++;
            $display("FAIL full_release: got push=%b, required 1", qPushReq_OUT);
        end
        exp_pc += 32'd4; exp_cnt++;
        step();
        @(negedge clk);
        n_vec++;
        if (memAddr_OUT !== 32'h14 || memReq_OUT !== 1'b1 || fetchCount_OUT !== exp_cnt) begin
            n_err++;
            $display("FAIL full_next: got addr=%h req=%b cnt=%0d, required 00000014 1 %0d",
                     memAddr_OUT, memReq_OUT, fetchCount_OUT, exp_cnt);
        end
    endtask

    task automatic test_redirect_req();
        memAck_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({exp_pc, memd(exp_pc)});
            step(); exp_pc += 32'd4; exp_cnt++;
            step();
        end
        memAck_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (memReq_OUT !== 1'b1 || memAddr_OUT !== 32'h20) begin
                n_err++;
                $display("FAIL rdr_wait%0d: got req=%b addr=%h, required 1 00000020", i, memReq_OUT, memAddr_OUT);
            end
            step();
        end
        // The ack arriving with the redirect must be dropped.
        redirect_IN = 1'b1; redirectPC_IN = 32'h100; memAck_IN = 1'b1;
        step();
        redirect_IN = 1'b0;
        @(negedge clk);
        n_vec++;
        if (qFlush_OUT !== 1'b1 || memReq_OUT !== 1'b0 || pc_OUT !== 32'h100) begin
            n_err++;
            $display("FAIL rdr_flush: got flush=%b req=%b pc=%h, required 1 0 00000100", qFlush_OUT, memReq_OUT, pc_OUT);
        end
        step();
        exp_pc = 32'h100;
        @(negedge clk);
        n_vec++;
        if (qFlush_OUT !== 1'b0 || memReq_OUT !== 1'b1 || memAddr_OUT !== 32'h100) begin
            n_err++;
            $display("FAIL rdr_resume: got flush=%b req=%b addr=%h, required 0 1 00000100", qFlush_OUT, memReq_OUT, memAddr_OUT);
        end
    endtask

    task automatic test_redirect_push();
        // Capture at 0x100; redirect arrives at the push opportunity so no entry is expected.
        memAck_IN = 1'b1;
        step();
        memAck_IN = 1'b0; redirect_IN = 1'b1; redirectPC_IN = 32'h200;
        @(negedge clk);
        n_vec++;
        if (qPushReq_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL rdp_push: got push=%b, required 0", qPushReq_OUT);
        end
        step();
        redirect_IN = 1'b0;
        @(negedge clk);
        n_vec++;
        if (qFlush_OUT !== 1'b1 || fetchCount_OUT !== exp_cnt || pc_OUT !== 32'h200) begin
            n_err++;
            $display("FAIL rdp_flush: got flush=%b cnt=%0d pc=%h, required 1 %0d 00000200", qFlush_OUT, fetchCount_OUT, pc_OUT, exp_cnt);
        end
        step();
        exp_pc = 32'h200;
        @(negedge clk);
        n_vec++;
        if (memReq_OUT !== 1'b1 || memAddr_OUT !== 32'h200) begin
            n_err++;
            $display("FAIL rdp_resume: got req=%b addr=%h, required 1 00000200", memReq_OUT, memAddr_OUT);
        end
    endtask

    task automatic test_stop();
        stop_IN = 1'b1; memAck_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (memReq_OUT !== 1'b0 || memAddr_OUT !== 32'h200) begin
                n_err++;
                $display("FAIL stop_hold%0d: got req=%b addr=%h, required 0 00000200", i, memReq_OUT, memAddr_OUT);
            end
            step();
        end
        stop_IN = 1'b0;
        @(negedge clk);
        n_vec++;
        if (memReq_OUT !== 1'b1 || memAddr_OUT !== 32'h200) begin
            n_err++;
            $display("FAIL stop_resume: got req=%b addr=%h, required 1 00000200", memReq_OUT, memAddr_OUT);
        end
        exp_q.push_back({exp_pc, memd(exp_pc)});
        step(); exp_pc += 32'd4; exp_cnt++;
        memAck_IN = 1'b0;
        step();
    endtask

    task automatic test_double_redirect();
        redirect_IN = 1'b1; redirectPC_IN = 32'h300;
        step();
        redirectPC_IN = 32'h400;
        step();
        redirect_IN = 1'b0;
        @(negedge clk);
        n_vec++;
        if (qFlush_OUT !== 1'b1 || pc_OUT !== 32'h400) begin
            n_err++;
            $display("FAIL dbl_flush: got flush=%b pc=%h, required 1 00000400", qFlush_OUT, pc_OUT);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (qFlush_OUT !== 1'b0 || memReq_OUT !== 1'b1 || memAddr_OUT !== 32'h400) begin
            n_err++;
            $display("FAIL dbl_resume: got flush=%b req=%b addr=%h, required 0 1 00000400", qFlush_OUT, memReq_OUT, memAddr_OUT);
        end
    endtask

    task automatic test_wrap();
        redirect_IN = 1'b1; redirectPC_IN = 32'hFFFF_FFFC;
        step();
        redirect_IN = 1'b0;
        step();
        exp_pc = 32'hFFFF_FFFC;
        memAck_IN = 1'b1;
        exp_q.push_back({exp_pc, memd(exp_pc)});
        step(); exp_pc += 32'd4; exp_cnt++;
        memAck_IN = 1'b0;
        step();
        @(negedge clk);
        n_vec++;
        if (memAddr_OUT !== 32'h0 || fetchCount_OUT !== exp_cnt) begin
            n_err++;
            $display("FAIL wrap_pc: got addr=%h cnt=%0d, required 00000000 %0d", memAddr_OUT, fetchCount_OUT, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        // Capture, then sit in S_PUSH behind a full FIFO; that entry is aborted by reset.
        memAck_IN = 1'b1; qFull_IN = 1'b1;
        step();
        memAck_IN = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({memReq_OUT, qPushReq_OUT, qFlush_OUT} !== 3'b000 || pc_OUT !== 32'h0 ||
            fetchCount_OUT !== 16'h0 || qData_OUT !== 64'h0) begin
            n_err++;
            $display("FAIL async_reset: got req=%b push=%b flush=%b pc=%h cnt=%0d data=%h, required all zero",
                     memReq_OUT, qPushReq_OUT, qFlush_OUT, pc_OUT, fetchCount_OUT, qData_OUT);
        end
        step();
        reset = 1'b1; qFull_IN = 1'b0; memAck_IN = 1'b1;
        exp_pc = 32'h0; exp_cnt = 16'h0;
        step();
        @(negedge clk);
        n_vec++;
        if (memReq_OUT !== 1'b1 || memAddr_OUT !== 32'h0 || fetchCount_OUT !== 16'h0) begin
            n_err++;
            $display("FAIL post_reset: got req=%b addr=%h cnt=%0d, required 1 00000000 0", memReq_OUT, memAddr_OUT, fetchCount_OUT);
        end
        exp_q.push_back({exp_pc, memd(exp_pc)});
        step(); exp_cnt++;
        memAck_IN = 1'b0;
        step();
        @(negedge clk);
        n_vec++;
        if (fetchCount_OUT !== exp_cnt || memAddr_OUT !== 32'h4) begin
            n_err++;
            $display("FAIL post_reset_cnt: got cnt=%0d addr=%h, required %0d 00000004", fetchCount_OUT, memAddr_OUT, exp_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_full();
        test_redirect_req();
        test_redirect_push();
        test_stop();
        test_double_redirect();
        test_wrap();
        test_async_reset();
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule

// File: doc/ifetch_queue_filler.md
Name: ifetch_queue_filler

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction FIFO.
- Walks a program counter and issues one read per instruction to instruction memory over a req/ack handshake.
- Pushes each returned {pc, instruction} entry into the FIFO, honouring its full flag.
- On a branch/exception redirect, discards in-flight work, pulses the FIFO flush and restarts fetch at the new PC.

Parameters:
- INSTR_WIDTH, 32, instruction word width in bits.
- PC_WIDTH, 32, program counter width in bits.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- stop_IN  in  1  1 = do not start new memory requests (fetch paused).
- redirect_IN  in  1  1 = load redirectPC_IN, discard in-flight work, flush the FIFO.
- redirectPC_IN  in  PC_WIDTH  new fetch address.
- memReq_OUT  out  1  read request to instruction memory.
- memAddr_OUT  out  PC_WIDTH  read address (= pc while memReq_OUT is 1).
- memAck_IN  in  1  memory returns memData_IN this cycle for the current request.
- memData_IN  in  INSTR_WIDTH  instruction word, valid when memAck_IN is 1.
- qFull_IN  in  1  FIFO full flag.
- qPushReq_OUT  out  1  FIFO push request.
- qData_OUT  out  PC_WIDTH+INSTR_WIDTH  FIFO entry {pc, instr}, pc in MSBs.
- qFlush_OUT  out  1  FIFO flush.
- pc_OUT  out  PC_WIDTH  current fetch PC.
- fetchCount_OUT  out  16  count of accepted pushes, wraps modulo 2^16.

Behaviour:
- States: S_START, S_REQ, S_PUSH, S_FLUSH.
- Reset (reset=0, async): state=S_START, pc=RESET_PC, hold reg=0, fetchCount=0.
  - All outputs are 0 except memAddr_OUT/pc_OUT=RESET_PC and qData_OUT=0.
  - Reset mid-operation aborts everything immediately; no push or flush is emitted.
- S_START: all handshake outputs 0. Next state S_REQ (or S_FLUSH if redirect_IN=1).
- S_REQ:
  - memReq_OUT = !stop_IN.
  - Memory holds memAck_IN low until it answers; the address is stable while memReq_OUT=1.
  - If memReq_OUT=1 and memAck_IN=1: capture {pc, memData_IN} into the hold reg, next S_PUSH.
  - memAck_IN while memReq_OUT=0 is ignored.
- S_PUSH:
  - memReq_OUT=0; qData_OUT=hold reg (registered, so data is stable before push).
  - qPushReq_OUT = !qFull_IN && !redirect_IN (combinational).
  - On push: pc <= pc+PC_STEP (wraps modulo 2^PC_WIDTH), fetchCount+1, next S_REQ.
  - While qFull_IN=1: stay in S_PUSH, hold data, no push.
- S_FLUSH (one cycle):
  - qFlush_OUT=1, memReq_OUT=0, qPushReq_OUT=0; any memAck_IN is ignored.
  - Next S_REQ.
- Redirect, highest priority, in any state including S_FLUSH:
  - pc <= redirectPC_IN; hold reg is discarded; next S_FLUSH.
  - A memAck_IN in the redirect cycle is dropped and no push occurs in that cycle.
  - Redirect while already in S_FLUSH reloads pc and stays in S_FLUSH one more cycle.
- Dropping memReq_OUT cancels an outstanding memory request.
- Throughput: at most one push per 2 cycles (req/ack cycle + push cycle).
- qPushReq_OUT is never 1 while qFull_IN=1, and never in the same cycle as qFlush_OUT=1.
- fetchCount is not cleared by redirect, only by reset.

Test Plan:
- Reset release, memAck_IN=1 every cycle, qFull_IN=0 -> memAddr 0,4,8,12 on alternate cycles; pushes {0,I0},{4,I1},{8,I2}; fetchCount=3 after the third push.
- Ack at pc=0x10 with qFull_IN=1 for 5 cycles -> no push and memReq_OUT=0 for 5 cycles; push {0x10,data} in the first cycle qFull_IN=0; next memAddr=0x14.
- memReq_OUT=1 at pc=0x20, memAck_IN held low 3 cycles, redirect_IN=1 to 0x100 -> next cycle qFlush_OUT=1 for exactly 1 cycle, memReq_OUT=0; following cycle memReq_OUT=1, memAddr=0x100.
- Redirect to 0x200 in the same cycle as an S_PUSH push opportunity -> qPushReq_OUT=0, flush pulse, fetchCount unchanged, next fetch at 0x200.
- stop_IN=1 in S_REQ with memAck_IN=1 -> memReq_OUT=0, no capture; on stop_IN=0 fetch resumes at the same pc.
- Assert reset low mid-S_PUSH between clock edges -> outputs go to reset values immediately; after release, first memAddr=RESET_PC and fetchCount=0.
